// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the unified memory and the arbiter.
// The arbiter takes the slave modport; the pipeline/memory side takes master.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata,
        output if_ready, if_rdata,
        output mem_ready, mem_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata,
        input  if_ready, if_rdata,
        input  mem_ready, mem_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  busy
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory between fetch and load/store.
// Optional perf counters are enabled with the ARB_PERF_CNT_EN macro.
module imem_dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    imem_dmem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0] perf_conflict_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam int CNT_W = 4;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              squash_q, squash_d;

    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              busy_q, busy_d;

    logic mem_elig;
    logic if_elig;
    logic flush_hit;
    logic complete;
    logic if_suppress;

    // A port whose ready pulse is high is about to drop its request, so it must not be re-granted.
    assign mem_elig    = bus.mem_req & ~mem_ready_q;
    assign if_elig     = bus.if_req & ~if_ready_q & ~bus.if_flush;
    assign flush_hit   = (state_q != IDLE) && (owner_q == OWN_IF) && bus.if_flush;
    assign complete    = (state_q == WAIT) && (cnt_q == '0);
    assign if_suppress = squash_q | flush_hit;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        squash_d    = squash_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (mem_elig) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_MEM;
                    we_d        = bus.mem_we;
                    squash_d    = 1'b0;
                    cnt_d       = CNT_W'(MEM_LAT);
                    ram_en_d    = 1'b1;
                    ram_we_d    = bus.mem_we;
                    ram_addr_d  = bus.mem_addr;
                    ram_wdata_d = bus.mem_wdata;
                end else if (if_elig) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_IF;
                    we_d        = 1'b0;
                    squash_d    = 1'b0;
                    cnt_d       = CNT_W'(MEM_LAT);
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = bus.if_addr;
                    ram_wdata_d = '0;
                end
            end
            ISSUE: begin
                state_d  = WAIT;
                cnt_d    = cnt_q - CNT_W'(1);
                squash_d = if_suppress;
            end
            WAIT: begin
                if (complete) begin
                    // ram_rdata is valid only on this edge; route it to the owner.
                    state_d  = IDLE;
                    squash_d = 1'b0;
                    if (owner_q == OWN_MEM) begin
                        mem_ready_d = 1'b1;
                        if (!we_q) begin
                            mem_rdata_d = bus.ram_rdata;
                        end
                    end else if (!if_suppress) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.ram_rdata;
                    end
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    squash_d = if_suppress;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            squash_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            squash_q    <= squash_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.busy      = busy_q;

`ifdef ARB_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] conflict_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
            flush_q    <= '0;
        end else begin
            if ((state_q == IDLE) && mem_elig && if_elig) begin
                conflict_q <= sat_inc(conflict_q);
            end
            if (complete && (owner_q == OWN_IF) && if_suppress) begin
                flush_q <= sat_inc(flush_q);
            end
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_flush_cnt    = flush_q;
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: stimulus pushes expected issues and
// completions, a negedge monitor pops and compares them against the DUT.
module tb_imem_dmem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } iss_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    iss_t iss_q[$];
    rsp_t if_q[$];
    rsp_t mem_q[$];

    imem_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_conflict_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    imem_dmem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict_cnt(perf_conflict_cnt),
        .perf_flush_cnt   (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed MEM_LAT read pipeline; garbage outside the valid slot.
    logic [31:0] ram_mem [logic [31:0]];
    bit   [31:0] rd_pipe [MEM_LAT];
    bit          rd_vld  [MEM_LAT];

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_wdata;
        rd_pipe[0] <= (bus.ram_en && !bus.ram_we) ? ram_read(bus.ram_addr) : 32'h0;
        rd_vld[0]  <= bus.ram_en && !bus.ram_we;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= rd_vld[i-1];
        end
    end

    assign bus.ram_rdata = rd_vld[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    iss_t mon_iss;
    rsp_t mon_rsp;
    always @(negedge clk) begin
        if (bus.ram_en) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_ram_en", bus.ram_addr, 32'hFFFF_FFFF);
            end else begin
                mon_iss = iss_q.pop_front();
                chk("issue_cycle", cyc, mon_iss.cyc);
                chk("issue_addr", bus.ram_addr, mon_iss.addr);
                chk("issue_we", {31'h0, bus.ram_we}, {31'h0, mon_iss.we});
                if (mon_iss.we) chk("issue_wdata", bus.ram_wdata, mon_iss.wdata);
            end
        end else begin
            chk("ram_we_without_en", {31'h0, bus.ram_we}, 32'h0);
        end
        if (bus.if_ready) begin
            if (if_q.size() == 0) begin
                chk("unexpected_if_ready", bus.if_rdata, 32'hFFFF_FFFF);
            end else begin
                mon_rsp = if_q.pop_front();
                chk("if_ready_cycle", cyc, mon_rsp.cyc);
                chk("if_rdata", bus.if_rdata, mon_rsp.data);
            end
        end
        if (bus.mem_ready) begin
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_ready", bus.mem_rdata, 32'hFFFF_FFFF);
            end else begin
                mon_rsp = mem_q.pop_front();
                chk("mem_ready_cycle", cyc, mon_rsp.cyc);
                chk("mem_rdata", bus.mem_rdata, mon_rsp.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // dly shifts the expected issue/completion when another port is served first.
    task automatic issue_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input int dly);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        iss_q.push_back('{addr: addr, we: we, wdata: wdata, cyc: cyc + 1 + dly});
        mem_q.push_back('{data: exp_rdata, cyc: cyc + MEM_LAT + 2 + dly});
    endtask

    task automatic issue_if(input logic [31:0] addr, input logic [31:0] exp_rdata, input int dly);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        iss_q.push_back('{addr: addr, we: 1'b0, wdata: 32'h0, cyc: cyc + 1 + dly});
        if_q.push_back('{data: exp_rdata, cyc: cyc + MEM_LAT + 2 + dly});
    endtask

    // Hold requests through their ready pulse, drop them the following cycle.
    task automatic wait_done(input bit w_if, input bit w_mem, input bit keep_if);
        bit d_if;
        bit d_mem;
        int n;
        d_if  = !w_if;
        d_mem = !w_mem;
        n     = 0;
        while (!(d_if && d_mem) && n < 40) begin
            step();
            n++;
            if (w_mem && d_mem) bus.mem_req = 1'b0;
            if (w_if && d_if && !keep_if) bus.if_req = 1'b0;
            if (!d_if && bus.if_ready) d_if = 1'b1;
            if (!d_mem && bus.mem_ready) d_mem = 1'b1;
        end
        if (!(d_if && d_mem)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: if_done=%0d mem_done=%0d, both required", d_if, d_mem);
        end
        step();
        if (w_mem) bus.mem_req = 1'b0;
        if (w_if && !keep_if) bus.if_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ready"},  {31'h0, bus.if_ready},  32'h0);
        chk({tag, "_if_rdata"},  bus.if_rdata,           32'h0);
        chk({tag, "_mem_ready"}, {31'h0, bus.mem_ready}, 32'h0);
        chk({tag, "_mem_rdata"}, bus.mem_rdata,          32'h0);
        chk({tag, "_ram_en"},    {31'h0, bus.ram_en},    32'h0);
        chk({tag, "_ram_we"},    {31'h0, bus.ram_we},    32'h0);
        chk({tag, "_ram_addr"},  bus.ram_addr,           32'h0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata,          32'h0);
        chk({tag, "_busy"},      {31'h0, bus.busy},      32'h0);
`ifdef ARB_PERF_CNT_EN
        chk({tag, "_perf_conflict"}, {16'h0, perf_conflict_cnt}, 32'h0);
        chk({tag, "_perf_flush"},    {16'h0, perf_flush_cnt},    32'h0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;

        ram_mem[32'h100] = 32'hDEAD_BEEF;
        ram_mem[32'h104] = 32'h5A5A_5A5A;
        ram_mem[32'h300] = 32'h0BAD_CAFE;
        ram_mem[32'h400] = 32'hCAFE_F00D;
        ram_mem[32'h000] = 32'h1111_0000;
        ram_mem[32'h004] = 32'h2222_0004;
        ram_mem[32'h008] = 32'h3333_0008;

        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // Single load, request held through mem_ready; busy r+1..r+3.
        issue_mem(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t1_busy", {31'h0, bus.busy}, (k < 4) ? 32'h1 : 32'h0);
        end
        step();
        bus.mem_req = 1'b0;
        repeat (3) step();

        // Simultaneous store and fetch: MEM first, IF issued in the mem_ready cycle + 1.
        issue_mem(1'b1, 32'h200, 32'h1234_5678, 32'hDEAD_BEEF, 0);
        issue_if(32'h0, 32'h1111_0000, MEM_LAT + 2);
        wait_done(1'b1, 1'b1, 1'b0);
`ifdef ARB_PERF_CNT_EN
        chk("perf_conflict_cnt", {16'h0, perf_conflict_cnt}, 32'h1);
`endif
        repeat (2) step();

        // Fetch 0x400 squashed by a flush pulse at r+2.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        iss_q.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0, cyc: cyc + 1});
        step();
        step();
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        step();
        bus.if_flush = 1'b0;
        chk("t3_busy_r3", {31'h0, bus.busy}, 32'h1);
        step();
        chk("t3_busy_r4", {31'h0, bus.busy}, 32'h0);
        chk("t3_if_rdata_kept", bus.if_rdata, 32'h1111_0000);
`ifdef ARB_PERF_CNT_EN
        chk("perf_flush_cnt", {16'h0, perf_flush_cnt}, 32'h1);
`endif
        repeat (3) step();

        // Read back the earlier store.
        issue_mem(1'b0, 32'h200, 32'h0, 32'h1234_5678, 0);
        wait_done(1'b0, 1'b1, 1'b0);
        step();

        // Reset during WAIT of a load; the in-flight response is discarded.
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h300;
        iss_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, cyc: cyc + 1});
        step();
        step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        bus.mem_req = 1'b0;
        chk_all_zero("rst_mid");
        repeat (2) step();
        issue_mem(1'b0, 32'h104, 32'h0, 32'h5A5A_5A5A, 0);
        wait_done(1'b0, 1'b1, 1'b0);
        step();

        // Continuous fetch stream; next address presented the cycle after if_ready.
        issue_if(32'h0, 32'h1111_0000, 0);
        wait_done(1'b1, 1'b0, 1'b1);
        issue_if(32'h4, 32'h2222_0004, 0);
        wait_done(1'b1, 1'b0, 1'b1);
        issue_if(32'h8, 32'h3333_0008, 0);
        wait_done(1'b1, 1'b0, 1'b0);
        repeat (4) step();

        chk("iss_q_drained", iss_q.size(), 32'h0);
        chk("if_q_drained",  if_q.size(),  32'h0);
        chk("mem_q_drained", mem_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
